serial_compare_sequencer: RTL and testbench
===========================================

Name: serial_compare_sequencer

Overview:
Multi-cycle magnitude comparator controller. Accepts two WIDTH-bit unsigned operands plus ripple cascade inputs and walks them MSB-first, one SLICE-bit slice per cycle, through a single shared slice comparator. It replaces a wide ripple comparator where area matters more than latency. It sits between an operand producer and result consumer using valid/ready handshakes on both sides.

Parameters:
WIDTH, 32, operand width in bits; must be a multiple of SLICE (elaboration error otherwise)
SLICE, 4, bits compared per cycle; 1 <= SLICE <= WIDTH
NSLICES, WIDTH/SLICE, derived localparam, not overridable

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  operand/cascade bundle valid
in_ready  out  1  block can accept bundle
a  in  WIDTH  operand A, unsigned
b  in  WIDTH  operand B, unsigned
gti  in  1  cascade greater-than from less-significant stage
lti  in  1  cascade less-than from less-significant stage
eqi  in  1  cascade equal from less-significant stage
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
gto  out  1  A > B (after cascade)
lto  out  1  A < B (after cascade)
eqo  out  1  A == B (after cascade)
slices_used  out  $clog2(NSLICES)+1  slices evaluated for this result

Behaviour:
- Clock/reset: single clock clk; rst asynchronous, active-high. While rst is high: state=IDLE, in_ready=0, out_valid=0, gto=0, lto=0, eqo=0, slices_used=0, slice index=NSLICES-1.
- FSM states IDLE, RUN, DONE. in_ready = (state==IDLE) && !rst.
- IDLE: on in_valid && in_ready, register a, b, gti/lti/eqi; clear decision flags (dec_gt=dec_lt=0); idx=NSLICES-1; go to RUN.
- RUN: each cycle, compare a[idx*SLICE +: SLICE] vs b[same] in the slice sub-module; increment slices_used.
  - Slice differs: set dec_gt or dec_lt.
  - idx==0, or decided with EARLY_EXIT_EN defined: go to DONE; otherwise idx-1.
  - Once decided, later slices never change the decision.
- DONE: out_valid=1. If decided: gto=dec_gt, lto=dec_lt, eqo=0. If all slices equal: gto/lto/eqo = captured gti/lti/eqi, passed through raw, even if not one-hot. Outputs and slices_used hold stable until out_valid && out_ready; then go to IDLE and drop out_valid.
- Latency (accept edge to out_valid=1): NSLICES cycles without early exit; k cycles with early exit, where k is the number of slices evaluated up to and including the first differing slice (NSLICES if equal).
- Throughput: one compare in flight; in_ready low in RUN/DONE, so input changes there are ignored. Back-to-back: in_ready rises the cycle after the output handshake.
- Operand registers are the only source during RUN.
- rst mid-RUN/DONE: in-flight compare discarded, no out_valid pulse; return to reset values.
- out_ready high before DONE has no effect.

Optional Feature:
EARLY_EXIT_EN.
- Defined: RUN terminates on the first deciding slice; latency data-dependent; slices_used = slices evaluated.
- Undefined: every compare takes exactly NSLICES cycles and slices_used always equals NSLICES; results identical.

Decomposition:
- Shared package cmp_pkg: FSM state enum (IDLE/RUN/DONE), 3-bit result encoding constants (GT=3'b100, LT=3'b010, EQ=3'b001), and a function returning NSLICES and the slices_used width for given WIDTH/SLICE.
- One sub-module, compare_slice: purely combinational SLICE-bit unsigned comparator with gt/lt/eq outputs, instantiated once.

Test Plan:
All with WIDTH=32, SLICE=4.
- a=15, b=28, cascade eqi=1, out_ready=1 -> lto=1, gto=0, eqo=0; out_valid 8 cycles after accept (7 with EARLY_EXIT_EN, slices_used=7).
- a=32'h8000_0000, b=32'h7FFF_FFFF -> gto=1, lto=0, eqo=0; latency 1 and slices_used=1 with EARLY_EXIT_EN, 8 and 8 without.
- a=b=32'hDEAD_BEEF, gti=1, lti=0, eqi=0 -> gto=1, lto=0, eqo=0 after 8 cycles; repeat with eqi=1 only -> eqo=1.
- Backpressure: a=3, b=5, hold out_ready=0 for 5 cycles after out_valid -> outputs and slices_used stable, in_ready=0, new in_valid ignored; release -> in_ready=1 next cycle.
- Reset mid-RUN: accept a=1, b=2, assert rst 3 cycles later -> out_valid never pulses, all outputs 0 immediately; after release, compare a=9, b=9, eqi=1 -> eqo=1.
- Back-to-back: two bundles queued with in_valid held high -> both accepted in order, one result each, no bundle lost or duplicated.

Source files
------------

// File: rtl/cmp_pkg.sv
// cmp_pkg
// Shared definitions for the serial magnitude comparator:
//   state_t   - controller states (IDLE / RUN / DONE)
//   RES_*     - 3-bit {gt, lt, eq} result encodings
//   cmp_dims  - slice count and slices_used width for a WIDTH/SLICE pair
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] RES_GT = 3'b100;
    localparam logic [2:0] RES_LT = 3'b010;
    localparam logic [2:0] RES_EQ = 3'b001;

    typedef struct packed {
        int unsigned nslices;
        int unsigned used_w;
    } dims_t;

    // slices_used must be able to hold NSLICES itself, hence the +1.
    function automatic dims_t cmp_dims(input int unsigned width, input int unsigned slice);
        dims_t d;
        d.nslices = (slice == 0) ? 1 : width / slice;
        d.used_w  = $clog2(d.nslices) + 1;
        return d;
    endfunction

endpackage

// File: rtl/compare_slice.sv
// compare_slice
// Purely combinational unsigned comparator for one SLICE-bit slice.
// Ports:
//   a, b  in  SLICE  slice operands
//   gt    out 1      a > b
//   lt    out 1      a < b
//   eq    out 1      a == b
module compare_slice
    import cmp_pkg::*;
#(
    parameter int unsigned SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    always_comb begin
        gt = (a > b);
        lt = (a < b);
        eq = (a == b);
    end

endmodule

// File: rtl/serial_compare_sequencer.sv
// serial_compare_sequencer
// Multi-cycle magnitude comparator. Operands are walked MSB-first, one
// SLICE-bit slice per cycle, through a single compare_slice instance. The
// first differing slice decides the result; if every slice is equal the
// captured cascade inputs are passed through unchanged.
//
// Optional build macro: EARLY_EXIT_EN - stop walking at the first deciding
// slice (data-dependent latency). Undefined: always NSLICES cycles.
//
// Ports:
//   clk, rst          clock (rising edge), async active-high reset
//   in_valid/in_ready input handshake for {a, b, gti, lti, eqi}
//   a, b              WIDTH-bit unsigned operands
//   gti, lti, eqi     cascade from the less-significant stage
//   out_valid/out_ready output handshake
//   gto, lto, eqo     comparison result (after cascade)
//   slices_used       slices evaluated for the current result
module serial_compare_sequencer
    import cmp_pkg::*;
#(
    parameter  int unsigned WIDTH   = 32,
    parameter  int unsigned SLICE   = 4,
    localparam dims_t       DIMS    = cmp_dims(WIDTH, SLICE),
    localparam int unsigned NSLICES = DIMS.nslices,
    localparam int unsigned USED_W  = DIMS.used_w
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              gti,
    input  logic              lti,
    input  logic              eqi,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              gto,
    output logic              lto,
    output logic              eqo,
    output logic [USED_W-1:0] slices_used
);

    localparam int unsigned IDX_W = (NSLICES > 1) ? $clog2(NSLICES) : 1;

    if (SLICE == 0 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_bad_cfg
        $error("serial_compare_sequencer: WIDTH must be a non-zero multiple of SLICE");
    end

    state_t state, state_nx;

    // Operands viewed as an array of slices; slice 0 holds the LSBs.
    logic [NSLICES-1:0][SLICE-1:0] a_q, b_q;
    logic                          gti_q, lti_q, eqi_q;
    logic                          dec_gt, dec_lt;
    logic [IDX_W-1:0]              idx;
    logic [USED_W-1:0]             used;

    logic s_gt, s_lt, s_eq;
    logic any_dec, nx_gt, nx_lt, run_last;
    logic [2:0] res;

    compare_slice #(.SLICE(SLICE)) u_slice (
        .a  (a_q[idx]),
        .b  (b_q[idx]),
        .gt (s_gt),
        .lt (s_lt),
        .eq (s_eq)
    );

    // A decision, once made, is sticky: lower slices cannot override it.
    assign any_dec = dec_gt | dec_lt;
    assign nx_gt   = dec_gt | (!any_dec && !s_eq && s_gt);
    assign nx_lt   = dec_lt | (!any_dec && !s_eq && s_lt);

`ifdef EARLY_EXIT_EN
    assign run_last = (idx == '0) || nx_gt || nx_lt;
`else
    assign run_last = (idx == '0);
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (in_valid)  state_nx = RUN;
            RUN:     if (run_last)  state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: operand capture, slice walk, decision tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            gti_q  <= 1'b0;
            lti_q  <= 1'b0;
            eqi_q  <= 1'b0;
            dec_gt <= 1'b0;
            dec_lt <= 1'b0;
            idx    <= IDX_W'(NSLICES - 1);
            used   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q    <= a;
                        b_q    <= b;
                        gti_q  <= gti;
                        lti_q  <= lti;
                        eqi_q  <= eqi;
                        dec_gt <= 1'b0;
                        dec_lt <= 1'b0;
                        idx    <= IDX_W'(NSLICES - 1);
                        used   <= '0;
                    end
                end
                RUN: begin
                    dec_gt <= nx_gt;
                    dec_lt <= nx_lt;
                    used   <= used + USED_W'(1);
                    if (!run_last) idx <= idx - IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == DONE);
        res       = '0;
        if (state == DONE) begin
            if (any_dec) res = dec_gt ? RES_GT : RES_LT;
            else         res = {gti_q, lti_q, eqi_q};
        end
        {gto, lto, eqo} = res;
        slices_used     = used;
    end

endmodule

// File: tb/tb_serial_compare_sequencer.sv
module tb_serial_compare_sequencer;

    localparam int W  = 32;
    localparam int S  = 4;
    localparam int NS = W / S;
    localparam int UW = $clog2(NS) + 1;
`ifdef EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready;
    logic [W-1:0]  a, b;
    logic          gti, lti, eqi;
    logic          out_valid, out_ready;
    logic          gto, lto, eqo;
    logic [UW-1:0] slices_used;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_compare_sequencer #(.WIDTH(W), .SLICE(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .gti        (gti),
        .lti        (lti),
        .eqi        (eqi),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .gto        (gto),
        .lto        (lto),
        .eqo        (eqo),
        .slices_used(slices_used)
    );

    // Reference model: whole-word magnitude comparison, cascade on equality.
    function automatic logic [2:0] model_res(input logic [W-1:0] x, y, input logic g, l, e);
        if (x > y) return 3'b100;
        if (x < y) return 3'b010;
        return {g, l, e};
    endfunction

    // Number of MSB-first slices needed to see the first difference.
    function automatic int model_used(input logic [W-1:0] x, y);
        if (!EE) return NS;
        for (int k = 1; k <= NS; k++)
            if ((x >> (W - k * S)) != (y >> (W - k * S))) return k;
        return NS;
    endfunction

    // Drives one bundle from IDLE, waits for the result, completes the
    // output handshake, and reports what was observed.
    task automatic run_one(input logic [W-1:0] va, vb, input logic vg, vl, ve,
                           output bit acc, output int lat, output logic [2:0] res,
                           output logic [UW-1:0] used, output bit post_ov, output bit post_ir);
        a = va; b = vb; gti = vg; lti = vl; eqi = ve;
        in_valid = 1'b1; out_ready = 1'b1;
        acc = in_ready;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; {gti, lti, eqi} = 3'($urandom);
        lat = 0;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        res  = {gto, lto, eqo};
        used = slices_used;
        @(posedge clk); #1;
        post_ov = out_valid;
        post_ir = in_ready;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        a = $urandom; b = $urandom; gti = 1'b1; lti = 1'b1; eqi = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({in_ready, out_valid, gto, lto, eqo} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected 00000", {in_ready, out_valid, gto, lto, eqo});
        end
        vectors++;
        if (slices_used !== '0) begin
            miscompares++;
            $display("FAIL reset_slices_used: got %0d expected 0", slices_used);
        end
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_in_ready: got %b expected 1", in_ready);
        end
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_out_valid: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [5] = '{32'd15, 32'h8000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h1234_5678};
        logic [W-1:0] tb [5] = '{32'd28, 32'h7FFF_FFFF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h1234_5678};
        logic [2:0]   tc [5] = '{3'b001, 3'b000, 3'b100, 3'b001, 3'b110};
        logic [2:0]   tr [5] = '{3'b010, 3'b100, 3'b100, 3'b001, 3'b110};
        int           tu [5] = '{7, 1, 8, 8, 8};
        bit acc, pov, pir; int lat, eu; logic [2:0] res; logic [UW-1:0] used;
        for (int i = 0; i < 5; i++) begin
            eu = EE ? tu[i] : NS;
            run_one(ta[i], tb[i], tc[i][2], tc[i][1], tc[i][0], acc, lat, res, used, pov, pir);
            vectors++;
            if (acc !== 1'b1) begin miscompares++; $display("FAIL dir%0d_accept: in_ready %b expected 1", i, acc); end
            vectors++;
            if (lat != eu) begin miscompares++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, eu); end
            vectors++;
            if (res !== tr[i]) begin miscompares++; $display("FAIL dir%0d_result: got %b expected %b", i, res, tr[i]); end
            vectors++;
            if (used !== UW'(eu)) begin miscompares++; $display("FAIL dir%0d_slices_used: got %0d expected %0d", i, used, eu); end
            vectors++;
            if (pov !== 1'b0 || pir !== 1'b1) begin
                miscompares++;
                $display("FAIL dir%0d_handshake: out_valid %b in_ready %b expected 0 1", i, pov, pir);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        a = 32'd3; b = 32'd5; gti = 1'b0; lti = 1'b0; eqi = 1'b0;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 64) begin @(posedge clk); #1; lat++; end
        vectors++;
        if (lat != NS) begin miscompares++; $display("FAIL bp_latency: got %0d expected %0d", lat, NS); end
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; a = $urandom; b = $urandom;
            @(posedge clk); #1;
            vectors++;
            if ({out_valid, in_ready, gto, lto, eqo} !== 5'b10010 || slices_used !== UW'(NS)) begin
                miscompares++;
                $display("FAIL bp_hold%0d: ov/ir/gt/lt/eq %b used %0d expected 10010 used %0d",
                         c, {out_valid, in_ready, gto, lto, eqo}, slices_used, NS);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release: out_valid %b in_ready %b expected 0 1", out_valid, in_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_no_ghost: out_valid %b expected 0", out_valid);
        end
    endtask

    task automatic test_reset_midrun();
        bit acc, pov, pir, seen; int lat; logic [2:0] res; logic [UW-1:0] used;
        a = 32'd1; b = 32'd2; gti = 1'b0; lti = 1'b0; eqi = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (seen || {in_ready, out_valid, gto, lto, eqo} !== 5'b0 || slices_used !== '0) begin
            miscompares++;
            $display("FAIL midrun_reset: pulse %b outs %b used %0d expected 0 00000 0",
                     seen, {in_ready, out_valid, gto, lto, eqo}, slices_used);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midrun_release: out_valid %b in_ready %b expected 0 1", out_valid, in_ready);
        end
        run_one(32'd9, 32'd9, 1'b0, 1'b0, 1'b1, acc, lat, res, used, pov, pir);
        vectors++;
        if (res !== 3'b001 || used !== UW'(NS) || lat != NS) begin
            miscompares++;
            $display("FAIL midrun_after: result %b used %0d latency %0d expected 001 %0d %0d", res, used, lat, NS, NS);
        end
    endtask

    task automatic test_random();
        bit acc, pov, pir; int lat, eu, k; logic [2:0] res, er; logic [UW-1:0] used;
        logic [W-1:0] va, vb, mask; logic [2:0] vc;
        for (int i = 0; i < 60; i++) begin
            va = $urandom; vc = 3'($urandom);
            case ($urandom_range(0, 2))
                0: vb = $urandom;
                1: vb = va;
                default: begin
                    k = $urandom_range(1, NS - 1);
                    mask = {W{1'b1}};
                    mask = mask << (k * S);
                    vb = (va & mask) | (W'($urandom) & ~mask);
                end
            endcase
            er = model_res(va, vb, vc[2], vc[1], vc[0]);
            eu = model_used(va, vb);
            run_one(va, vb, vc[2], vc[1], vc[0], acc, lat, res, used, pov, pir);
            vectors++;
            if (res !== er) begin
                miscompares++;
                $display("FAIL rnd%0d_result: a %h b %h c %b got %b expected %b", i, va, vb, vc, res, er);
            end
            vectors++;
            if (used !== UW'(eu) || lat != eu) begin
                miscompares++;
                $display("FAIL rnd%0d_slices: a %h b %h used %0d latency %0d expected %0d", i, va, vb, used, lat, eu);
            end
            vectors++;
            if (acc !== 1'b1 || pov !== 1'b0 || pir !== 1'b1) begin
                miscompares++;
                $display("FAIL rnd%0d_handshake: acc %b ov %b ir %b expected 1 0 1", i, acc, pov, pir);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] qa [3], qb [3]; logic [2:0] qc [3];
        logic [2:0] exp_res [$]; int exp_used [$];
        int sent, got, cyc; bit will_acc; logic [2:0] er; int eu;
        for (int i = 0; i < 3; i++) begin
            qa[i] = $urandom;
            qb[i] = (i == 1) ? qa[i] : W'($urandom);
            qc[i] = 3'($urandom);
        end
        sent = 0; got = 0; cyc = 0;
        out_ready = 1'b1;
        a = qa[0]; b = qb[0]; {gti, lti, eqi} = qc[0];
        in_valid = 1'b1;
        while (got < 3 && cyc < 200) begin
            will_acc = in_valid && in_ready;
            if (will_acc) begin
                exp_res.push_back(model_res(qa[sent], qb[sent], qc[sent][2], qc[sent][1], qc[sent][0]));
                exp_used.push_back(model_used(qa[sent], qb[sent]));
            end
            @(posedge clk); #1;
            cyc++;
            if (will_acc) begin
                sent++;
                if (sent < 3) begin
                    a = qa[sent]; b = qb[sent]; {gti, lti, eqi} = qc[sent];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                vectors++;
                if (exp_res.size() == 0) begin
                    miscompares++;
                    $display("FAIL b2b_extra_result: got %b with nothing outstanding", {gto, lto, eqo});
                end else begin
                    er = exp_res.pop_front();
                    eu = exp_used.pop_front();
                    if ({gto, lto, eqo} !== er || slices_used !== UW'(eu)) begin
                        miscompares++;
                        $display("FAIL b2b_result%0d: got %b used %0d expected %b used %0d",
                                 got, {gto, lto, eqo}, slices_used, er, eu);
                    end
                end
                got++;
            end
        end
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (out_valid) got++;
        end
        vectors++;
        if (sent != 3 || got != 3) begin
            miscompares++;
            $display("FAIL b2b_count: sent %0d results %0d expected 3 3", sent, got);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midrun();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
